// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } db_state_t;

    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles > 2) ? $clog2(stable_cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, delayed-acceptance FSM, registered edge pulses.
// Optional DEBOUNCE_TOGGLE_EN adds a latched toggle output flipped on each accepted rise.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic noisy_i,
    output logic level_o,
    output logic rise_o,
`ifdef DEBOUNCE_TOGGLE_EN
    output logic toggle_o,
`endif
    output logic fall_o
);

    localparam int            CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    db_state_t              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_in = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], noisy_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The counter only advances while qualifying, and stops at CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = STABLE_LOW;
        endcase
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_q ^ rise_d;
        end
    end

    assign toggle_o = toggle_q;
`endif

endmodule

// File: rtl/debouncer_multi_edge.sv
// N independent debounce channels with one-cycle rise/fall pulses per channel.
// Define DEBOUNCE_TOGGLE_EN to add toggle_out (bit flips on every accepted rise).
module debouncer_multi_edge
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 2_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] debounced_out,
    output logic [N_CH-1:0] rise_pulse,
`ifdef DEBOUNCE_TOGGLE_EN
    output logic [N_CH-1:0] toggle_out,
`endif
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clk_i    (clk),
            .rst_i    (reset),
            .noisy_i  (noisy_in[g]),
            .level_o  (debounced_out[g]),
            .rise_o   (rise_pulse[g]),
`ifdef DEBOUNCE_TOGGLE_EN
            .toggle_o (toggle_out[g]),
`endif
            .fall_o   (fall_pulse[g])
        );
    end

endmodule

// File: tb/tb_debouncer_multi_edge.sv
// Directed + random checks of debouncer_multi_edge against a run-length reference model.
module tb_debouncer_multi_edge;

    localparam int N  = 4;
    localparam int SC = 16;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] noisy_in;
    logic [N-1:0] debounced_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
`ifdef DEBOUNCE_TOGGLE_EN
    logic [N-1:0] toggle_out;
`endif

    debouncer_multi_edge #(
        .N_CH          (N),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .noisy_in      (noisy_in),
        .debounced_out (debounced_out),
        .rise_pulse    (rise_pulse),
`ifdef DEBOUNCE_TOGGLE_EN
        .toggle_out    (toggle_out),
`endif
        .fall_pulse    (fall_pulse)
    );

    always #5 clk = ~clk;

    // Reference: a level is accepted once the synchronised pin has disagreed with
    // the current output for SC+1 consecutive clock samples.
    logic [N-1:0] m_deb, m_rise, m_fall, m_tog;
    int           run [N];
    logic         hist [N][SS];
    int           rise_cnt [N];
    int           fall_cnt [N];
    int           passed = 0;
    int           total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_deb = '0; m_rise = '0; m_fall = '0; m_tog = '0;
        for (int c = 0; c < N; c++) begin
            run[c] = 0;
            for (int s = 0; s < SS; s++) hist[c][s] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic smp;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < N; c++) begin
            smp = hist[c][0];
            for (int s = 0; s < SS - 1; s++) hist[c][s] = hist[c][s+1];
            hist[c][SS-1] = noisy_in[c];
            if (smp != m_deb[c]) begin
                run[c]++;
                if (run[c] == SC + 1) begin
                    m_deb[c]  = smp;
                    m_rise[c] = smp;
                    m_fall[c] = !smp;
                    m_tog[c]  = m_tog[c] ^ smp;
                    run[c]    = 0;
                end
            end else begin
                run[c] = 0;
            end
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        chk("debounced_out", 32'(debounced_out), 32'(m_deb));
        chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
`ifdef DEBOUNCE_TOGGLE_EN
        chk("toggle_out", 32'(toggle_out), 32'(m_tog));
`endif
        for (int c = 0; c < N; c++) begin
            rise_cnt[c] += int'(rise_pulse[c]);
            fall_cnt[c] += int'(fall_pulse[c]);
        end
    endtask

    task automatic wait_deb(input int ch, input logic lvl, input int bound, output int n);
        n = 0;
        while (debounced_out[ch] !== lvl && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        noisy_in = '0;
        model_reset();
        clear_counts();
        #1;
        chk("reset_deb", 32'(debounced_out), 32'd0);
        chk("reset_pulses", 32'({rise_pulse, fall_pulse}), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();

        // Clean step on ch0
        clear_counts();
        noisy_in[0] = 1'b1;
        wait_deb(0, 1'b1, 40, n);
        chk("t1_latency", 32'(n), 32'd19);
        chk("t1_rise_at_edge", 32'(rise_pulse), 32'b0001);
        repeat (21) tick();
        chk("t1_rise_count", 32'(rise_cnt[0]), 32'd1);
        chk("t1_other_pulses", 32'(fall_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 32'd0);

        // Bouncing ch1, then held high
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            noisy_in[1] = ~noisy_in[1];
            repeat (5) tick();
        end
        chk("t2_no_change", 32'(debounced_out[1]), 32'd0);
        noisy_in[1] = 1'b1;
        wait_deb(1, 1'b1, 40, n);
        chk("t2_latency", 32'(n), 32'd19);
        repeat (3) tick();
        chk("t2_rise_count", 32'(rise_cnt[1]), 32'd1);

        // Short pulse on ch2 is swallowed
        clear_counts();
        noisy_in[2] = 1'b1;
        repeat (10) tick();
        noisy_in[2] = 1'b0;
        repeat (30) tick();
        chk("t3_level", 32'(debounced_out[2]), 32'd0);
        chk("t3_pulses", 32'(rise_cnt[2] + fall_cnt[2]), 32'd0);

        // Simultaneous release of ch0 and ch3
        noisy_in[3] = 1'b1;
        repeat (25) tick();
        chk("t4_setup", 32'(debounced_out), 32'b1011);
        clear_counts();
        noisy_in[0] = 1'b0;
        noisy_in[3] = 1'b0;
        n = 0;
        while (fall_pulse === '0 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_fall_vec", 32'(fall_pulse), 32'b1001);
        chk("t4_latency", 32'(n), 32'd19);
        chk("t4_levels", 32'(debounced_out), 32'b0010);
        repeat (5) tick();
        chk("t4_single_pulse", 32'(fall_cnt[0] + fall_cnt[3]), 32'd2);

        // Reset during ch1 qualification (cnt reaches 10 on the 13th edge)
        noisy_in[3] = 1'b1;
        noisy_in[1] = 1'b0;
        repeat (25) tick();
        chk("t5_setup", 32'(debounced_out), 32'b1000);
        noisy_in[1] = 1'b1;
        repeat (13) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t5_async_deb", 32'(debounced_out), 32'd0);
        chk("t5_async_pulses", 32'({rise_pulse, fall_pulse}), 32'd0);
`ifdef DEBOUNCE_TOGGLE_EN
        chk("t5_async_toggle", 32'(toggle_out), 32'd0);
`endif
        repeat (3) tick();
        reset = 1'b0;
        clear_counts();
        wait_deb(1, 1'b1, 40, n);
        chk("t5_relatency", 32'(n), 32'd19);
        chk("t5_early_pulses", 32'(rise_cnt[1] + fall_cnt[1]), 32'd1);

`ifdef DEBOUNCE_TOGGLE_EN
        // Toggle follows accepted rises only
        for (int k = 0; k < 3; k++) begin
            noisy_in[0] = 1'b1;
            wait_deb(0, 1'b1, 40, n);
            chk("t6_rise_aligned", 32'(rise_pulse[0]), 32'd1);
            chk("t6_toggle_on_rise", 32'(toggle_out[0]), 32'((k % 2) == 0));
            noisy_in[0] = 1'b0;
            wait_deb(0, 1'b0, 40, n);
            chk("t6_toggle_on_fall", 32'(toggle_out[0]), 32'((k % 2) == 0));
        end
`endif

        // Random bursts on all channels
        repeat (40) begin
            noisy_in = noisy_in ^ 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 30)) tick();
        end
        repeat (25) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
